// File: rtl/ddr_out_bank_if.sv
// Beat handshake between the write-data FIFO (master) and the DDR output bank (slave).
`timescale 1ns/1ps
interface ddr_out_bank_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_d0;
   logic [WIDTH-1:0] in_d1;

   modport master (output in_valid, output in_d0, output in_d1, input in_ready);
   modport slave  (input in_valid, input in_d0, input in_d1, output in_ready);
endinterface

// File: rtl/ddr_out_bank.sv
// DDR output staging bank: fixed-length bursts, retimed fall data, oe/dqs_en windows.
// Optional DDR_OUT_SEAMLESS_EN lets a new burst start in the first POST cycle.
`timescale 1ns/1ps
module ddr_out_bank #(
   parameter int WIDTH      = 16,
   parameter int BURST_LEN  = 4,
   parameter int PREAMBLE   = 1,
   parameter int POSTAMBLE  = 1,
   parameter int FALL_DELAY = 1
) (
   input  logic             sys_clk,
   input  logic             sys_rst_n,
   ddr_out_bank_if.slave    bus,
   input  logic             err_clr,
   output logic [WIDTH-1:0] q0,
   output logic [WIDTH-1:0] q1,
   output logic             oe,
   output logic             dqs_en,
   output logic             busy,
   output logic             underrun
);

`ifdef DDR_OUT_SEAMLESS_EN
   localparam bit SEAMLESS = 1'b1;
`else
   localparam bit SEAMLESS = 1'b0;
`endif

   localparam int CW = 5;
   localparam logic [CW-1:0] PRE_LAST  = CW'((PREAMBLE > 0) ? PREAMBLE - 1 : 0);
   localparam logic [CW-1:0] BL_LAST   = CW'(BURST_LEN - 1);
   localparam logic [CW-1:0] POST_LAST = CW'(POSTAMBLE - 1);

   typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] q0_q, q0_d;
   logic [WIDTH-1:0] fall0_q, fall0_d;
   logic [WIDTH-1:0] fall1_q, fall1_d;
   logic             oe_q, oe_d;
   logic             dqs_q, dqs_d;
   logic             ur_q, ur_d;
   logic             in_ready_c;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      q0_d       = '0;
      fall0_d    = '0;
      fall1_d    = fall0_q;
      dqs_d      = 1'b0;
      ur_d       = ur_q & ~err_clr;
      in_ready_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               cnt_d   = '0;
               state_d = (PREAMBLE > 0) ? PRE : DATA;
            end
         end
         PRE: begin
            if (cnt_q == PRE_LAST) begin
               state_d = DATA;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         DATA: begin
            // Missing beats still consume their slot so the burst length never stretches.
            in_ready_c = 1'b1;
            dqs_d      = 1'b1;
            if (bus.in_valid) begin
               q0_d    = bus.in_d0;
               fall0_d = bus.in_d1;
            end else begin
               ur_d = 1'b1;
            end
            if (cnt_q == BL_LAST) begin
               state_d = POST;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         POST: begin
            if (cnt_q == POST_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
            if (SEAMLESS && (cnt_q == '0)) begin
               in_ready_c = 1'b1;
               if (bus.in_valid) begin
                  q0_d    = bus.in_d0;
                  fall0_d = bus.in_d1;
                  dqs_d   = 1'b1;
                  state_d = (BURST_LEN == 1) ? POST : DATA;
                  cnt_d   = (BURST_LEN == 1) ? '0 : CW'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // oe lingers one extra cycle when the fall word is delayed, covering the last q1.
      oe_d = (state_d != IDLE) ||
             ((FALL_DELAY != 0) && (state_q == POST) && (state_d == IDLE));
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         q0_q    <= '0;
         fall0_q <= '0;
         fall1_q <= '0;
         oe_q    <= 1'b0;
         dqs_q   <= 1'b0;
         ur_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q0_q    <= q0_d;
         fall0_q <= fall0_d;
         fall1_q <= fall1_d;
         oe_q    <= oe_d;
         dqs_q   <= dqs_d;
         ur_q    <= ur_d;
      end
   end

   assign bus.in_ready = in_ready_c;
   assign q0           = q0_q;
   assign q1           = (FALL_DELAY == 0) ? fall0_q : fall1_q;
   assign oe           = oe_q;
   assign dqs_en       = dqs_q;
   assign busy         = (state_q != IDLE);
   assign underrun     = ur_q;

endmodule

// File: tb/tb_ddr_out_bank.sv
// Bench for ddr_out_bank: dut_a uses defaults, dut_b has PREAMBLE=0 and FALL_DELAY=0.
`timescale 1ns/1ps
module tb_ddr_out_bank;
   localparam int W = 16;

`ifdef DDR_OUT_SEAMLESS_EN
   localparam int POST_RDY = 1;
`else
   localparam int POST_RDY = 0;
`endif

   logic sys_clk = 1'b0;
   logic sys_rst_n = 1'b0;
   logic err_clr_a = 1'b0;
   logic err_clr_b = 1'b0;

   always #5 sys_clk = ~sys_clk;

   ddr_out_bank_if #(.WIDTH(W)) bus_a ();
   ddr_out_bank_if #(.WIDTH(W)) bus_b ();

   logic [W-1:0] a_q0, a_q1, b_q0, b_q1;
   logic a_oe, a_dqs, a_busy, a_ur;
   logic b_oe, b_dqs, b_busy, b_ur;

   ddr_out_bank #(.WIDTH(W), .BURST_LEN(4), .PREAMBLE(1), .POSTAMBLE(1), .FALL_DELAY(1)) dut_a (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_a), .err_clr(err_clr_a),
      .q0(a_q0), .q1(a_q1), .oe(a_oe), .dqs_en(a_dqs), .busy(a_busy), .underrun(a_ur)
   );

   ddr_out_bank #(.WIDTH(W), .BURST_LEN(4), .PREAMBLE(0), .POSTAMBLE(1), .FALL_DELAY(0)) dut_b (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus_b), .err_clr(err_clr_b),
      .q0(b_q0), .q1(b_q1), .oe(b_oe), .dqs_en(b_dqs), .busy(b_busy), .underrun(b_ur)
   );

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q0_a[$], exp_q1_a[$], exp_q0_b[$], exp_q1_b[$];
   int oe_cnt_a = 0, dqs_cnt_a = 0, rdy_cnt_a = 0, oe_fall_a = 0;
   int dqs_run_a = 0, dqs_max_a = 0, oe_cnt_b = 0;
   bit a_oe_prev = 1'b0, a_dqs_dly = 1'b0;
   int s_oe, s_dqs, s_rdy, s_fall;

   task automatic checkOutput(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(bit to_b, bit v, logic [W-1:0] d0, logic [W-1:0] d1, bit slot);
      if (to_b) begin
         bus_b.in_valid = v;
         bus_b.in_d0    = d0;
         bus_b.in_d1    = d1;
         if (slot) begin
            exp_q0_b.push_back(v ? d0 : '0);
            exp_q1_b.push_back(v ? d1 : '0);
         end
      end else begin
         bus_a.in_valid = v;
         bus_a.in_d0    = d0;
         bus_a.in_d1    = d1;
         if (slot) begin
            exp_q0_a.push_back(v ? d0 : '0);
            exp_q1_a.push_back(v ? d1 : '0);
         end
      end
   endtask

   // One clock: sample just after the edge, pop the scoreboard while dqs_en marks live data.
   task automatic tick();
      @(posedge sys_clk);
      #1;
      if (a_oe) oe_cnt_a++;
      if (a_oe_prev && !a_oe) oe_fall_a++;
      a_oe_prev = a_oe;
      if (bus_a.in_ready) rdy_cnt_a++;
      if (a_dqs) begin
         dqs_cnt_a++;
         dqs_run_a++;
         if (dqs_run_a > dqs_max_a) dqs_max_a = dqs_run_a;
         if (exp_q0_a.size() == 0) checkOutput("a_q0_extra", 32'(exp_q0_a.size()), 32'd1);
         else checkOutput("a_q0", 32'(a_q0), 32'(exp_q0_a.pop_front()));
      end else begin
         dqs_run_a = 0;
         checkOutput("a_q0_idle", 32'(a_q0), 32'd0);
      end
      if (a_dqs_dly) begin
         if (exp_q1_a.size() == 0) checkOutput("a_q1_extra", 32'(exp_q1_a.size()), 32'd1);
         else checkOutput("a_q1", 32'(a_q1), 32'(exp_q1_a.pop_front()));
      end else begin
         checkOutput("a_q1_idle", 32'(a_q1), 32'd0);
      end
      a_dqs_dly = a_dqs;
      if (b_oe) oe_cnt_b++;
      if (b_dqs) begin
         if (exp_q0_b.size() == 0 || exp_q1_b.size() == 0)
            checkOutput("b_q_extra", 32'(exp_q0_b.size()), 32'd1);
         else begin
            checkOutput("b_q0", 32'(b_q0), 32'(exp_q0_b.pop_front()));
            checkOutput("b_q1", 32'(b_q1), 32'(exp_q1_b.pop_front()));
         end
      end else begin
         checkOutput("b_q0_idle", 32'(b_q0), 32'd0);
         checkOutput("b_q1_idle", 32'(b_q1), 32'd0);
      end
   endtask

   // Full burst on dut_a from IDLE: trigger edge, one preamble edge, four beat slots.
   task automatic burstA(logic [W-1:0] b0, logic [W-1:0] b1, logic [3:0] drop, bit clr_on_drop);
      logic [W-1:0] d0, d1;
      applyStimulus(1'b0, 1'b1, b0, b1, 1'b0);
      checkOutput("a_idle_rdy", 32'(bus_a.in_ready), 32'd0);
      tick();
      checkOutput("a_pre_oe", 32'(a_oe), 32'd1);
      checkOutput("a_pre_busy", 32'(a_busy), 32'd1);
      checkOutput("a_pre_rdy", 32'(bus_a.in_ready), 32'd0);
      tick();
      checkOutput("a_data_rdy", 32'(bus_a.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         d0 = W'(b0 * (i + 1));
         d1 = W'(b1 + 16'h0101 * i);
         err_clr_a = clr_on_drop & drop[i];
         applyStimulus(1'b0, !drop[i], d0, d1, 1'b1);
         tick();
      end
      err_clr_a = 1'b0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   task automatic drainCheck(string tag);
      checkOutput({tag, "_q0a_left"}, 32'(exp_q0_a.size()), 32'd0);
      checkOutput({tag, "_q1a_left"}, 32'(exp_q1_a.size()), 32'd0);
      checkOutput({tag, "_q0b_left"}, 32'(exp_q0_b.size()), 32'd0);
      checkOutput({tag, "_q1b_left"}, 32'(exp_q1_b.size()), 32'd0);
   endtask

   initial begin
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      #12;
      checkOutput("rst_q0", 32'(a_q0), 32'd0);
      checkOutput("rst_q1", 32'(a_q1), 32'd0);
      checkOutput("rst_oe", 32'(a_oe), 32'd0);
      checkOutput("rst_dqs", 32'(a_dqs), 32'd0);
      checkOutput("rst_busy", 32'(a_busy), 32'd0);
      checkOutput("rst_ur", 32'(a_ur), 32'd0);
      checkOutput("rst_rdy", 32'(bus_a.in_ready), 32'd0);
      sys_rst_n = 1'b1;

      $display("[TB] basic burst");
      s_oe = oe_cnt_a; s_dqs = dqs_cnt_a; s_rdy = rdy_cnt_a;
      burstA(16'h1111, 16'hA1A1, 4'b0000, 1'b0);
      tick(); tick(); tick();
      checkOutput("t1_oe_cycles", 32'(oe_cnt_a - s_oe), 32'd7);
      checkOutput("t1_dqs_cycles", 32'(dqs_cnt_a - s_dqs), 32'd4);
      checkOutput("t1_rdy_cycles", 32'(rdy_cnt_a - s_rdy), 32'(4 + POST_RDY));
      checkOutput("t1_ur", 32'(a_ur), 32'd0);
      drainCheck("t1");

      $display("[TB] underrun");
      burstA(16'h0102, 16'hB1B1, 4'b0100, 1'b0);
      checkOutput("ur_set", 32'(a_ur), 32'd1);
      tick(); tick(); tick();
      checkOutput("ur_sticky", 32'(a_ur), 32'd1);
      drainCheck("t2a");
      err_clr_a = 1'b1;
      tick();
      err_clr_a = 1'b0;
      checkOutput("ur_clr", 32'(a_ur), 32'd0);
      burstA(16'h0203, 16'hB5B5, 4'b0010, 1'b1);
      checkOutput("ur_set_wins", 32'(a_ur), 32'd1);
      tick(); tick(); tick();
      drainCheck("t2b");
      err_clr_a = 1'b1;
      tick();
      err_clr_a = 1'b0;
      checkOutput("ur_clr2", 32'(a_ur), 32'd0);

      $display("[TB] no preamble, no fall delay");
      s_oe = oe_cnt_b;
      applyStimulus(1'b1, 1'b1, 16'h0A0A, 16'h5A5A, 1'b0);
      checkOutput("b_idle_rdy", 32'(bus_b.in_ready), 32'd0);
      tick();
      checkOutput("b_data_rdy", 32'(bus_b.in_ready), 32'd1);
      checkOutput("b_busy", 32'(b_busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, W'(16'h0A0A * (i + 1)), W'(16'h5A5A + 16'h0111 * i), 1'b1);
         tick();
      end
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0);
      tick(); tick(); tick();
      checkOutput("b_oe_cycles", 32'(oe_cnt_b - s_oe), 32'd5);
      checkOutput("b_ur", 32'(b_ur), 32'd0);
      drainCheck("t3");

      $display("[TB] back-to-back bursts");
      s_oe = oe_cnt_a; s_fall = oe_fall_a; dqs_max_a = 0;
      burstA(16'h1010, 16'hC1C1, 4'b0000, 1'b0);
`ifdef DDR_OUT_SEAMLESS_EN
      checkOutput("post_rdy", 32'(bus_a.in_ready), 32'd1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b0, 1'b1, W'(16'h0505 * (i + 1)), W'(16'hD1D1 + 16'h0101 * i), 1'b1);
         tick();
      end
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      tick(); tick(); tick();
      checkOutput("seam_dqs_run", 32'(dqs_max_a), 32'd8);
      checkOutput("seam_oe_falls", 32'(oe_fall_a - s_fall), 32'd1);
      checkOutput("seam_oe_cycles", 32'(oe_cnt_a - s_oe), 32'd11);
`else
      checkOutput("post_rdy", 32'(bus_a.in_ready), 32'd0);
      applyStimulus(1'b0, 1'b1, 16'h0505, 16'hD1D1, 1'b0);
      tick();
      checkOutput("post_tail_oe", 32'(a_oe), 32'd1);
      checkOutput("post_idle_busy", 32'(a_busy), 32'd0);
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      tick();
      checkOutput("gap_oe", 32'(a_oe), 32'd0);
      burstA(16'h0505, 16'hD1D1, 4'b0000, 1'b0);
      tick(); tick(); tick();
      checkOutput("gap_dqs_run", 32'(dqs_max_a), 32'd4);
      checkOutput("gap_oe_falls", 32'(oe_fall_a - s_fall), 32'd2);
      checkOutput("gap_oe_cycles", 32'(oe_cnt_a - s_oe), 32'd14);
`endif
      drainCheck("t4");

      $display("[TB] async reset mid-burst");
      applyStimulus(1'b0, 1'b1, 16'h7777, 16'hD7D7, 1'b0);
      tick();
      tick();
      applyStimulus(1'b0, 1'b1, 16'h7777, 16'hD7D7, 1'b1);
      tick();
      #1;
      sys_rst_n = 1'b0;
      #1;
      checkOutput("arst_q0", 32'(a_q0), 32'd0);
      checkOutput("arst_q1", 32'(a_q1), 32'd0);
      checkOutput("arst_oe", 32'(a_oe), 32'd0);
      checkOutput("arst_dqs", 32'(a_dqs), 32'd0);
      checkOutput("arst_busy", 32'(a_busy), 32'd0);
      checkOutput("arst_rdy", 32'(bus_a.in_ready), 32'd0);
      exp_q0_a.delete();
      exp_q1_a.delete();
      a_dqs_dly = 1'b0;
      a_oe_prev = 1'b0;
      dqs_run_a = 0;
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0);
      @(posedge sys_clk);
      #2;
      sys_rst_n = 1'b1;
      #1;
      checkOutput("rel_rdy", 32'(bus_a.in_ready), 32'd0);
      checkOutput("rel_busy", 32'(a_busy), 32'd0);
      tick();
      tick();
      checkOutput("rel_rdy_idle", 32'(bus_a.in_ready), 32'd0);
      checkOutput("rel_busy_idle", 32'(a_busy), 32'd0);
      s_oe = oe_cnt_a;
      burstA(16'h0F0F, 16'hE1E1, 4'b0000, 1'b0);
      tick(); tick(); tick();
      checkOutput("rel_oe_cycles", 32'(oe_cnt_a - s_oe), 32'd7);
      drainCheck("t5");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/ddr_out_bank.md
Name: ddr_out_bank

Overview:
- Parametrised DDR output staging bank for the hpdmc_ddr16 write datapath. It sits between the write-data FIFO and the per-bit ODDR2 primitives.
- Accepts fixed-length bursts of rise/fall word pairs through a valid/ready handshake. Presents registered rise and fall words, with the fall word retimed by a configurable number of cycles.
- Generates the DQ output-enable and DQS enable windows, including preamble and postamble.
- Generalises the single-bit fall-data retime stage to WIDTH bits, with burst sequencing and underrun detection added.

Parameters:
- WIDTH, 16: bits per rise/fall word.
- BURST_LEN, 4: sys_clk cycles (beats) per burst, 1..16.
- PREAMBLE, 1: cycles of oe before the first beat, 0..3.
- POSTAMBLE, 1: cycles of oe after the last beat, 1..3.
- FALL_DELAY, 1: extra retime cycles on fall data, 0 or 1.

Ports:
- sys_clk  in  1  single clock; all state on rising edge.
- sys_rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat available.
- in_ready  out  1  bank accepts beat this cycle.
- in_d0  in  WIDTH  rise-edge word.
- in_d1  in  WIDTH  fall-edge word.
- err_clr  in  1  clears underrun flag.
- q0  out  WIDTH  registered rise word to ODDR2 D0.
- q1  out  WIDTH  retimed fall word to ODDR2 D1.
- oe  out  1  DQ drive enable.
- dqs_en  out  1  DQS toggle enable; high exactly while q0 carries burst data.
- busy  out  1  state != IDLE.
- underrun  out  1  sticky: beat slot passed without in_valid.

Behaviour:
- Reset (sys_rst_n=0, async): state=IDLE; beat counter=0; q0=q1=0; all retime registers=0; oe=dqs_en=busy=underrun=0; in_ready=0.
- Reset mid-burst aborts immediately; the interrupted burst is never completed.
- FSM states: IDLE, PRE, DATA, POST.
- IDLE: in_ready=0. On a sys_clk edge with in_valid=1, go to PRE if PREAMBLE>0, else to DATA. The triggering in_valid is not consumed.
- PRE: stay PREAMBLE cycles, then go to DATA.
- DATA: in_ready=1 combinationally for exactly BURST_LEN cycles; the beat counter increments every DATA cycle.
- Each DATA edge with in_valid=1 loads q0<=in_d0 and fall stage 0<=in_d1.
- Each DATA edge with in_valid=0 is an underrun slot: q0<=0, fall stage 0<=0, underrun<=1. The counter still advances, so the burst length is fixed.
- After the BURST_LEN-th DATA edge, go to POST.
- POST: stay POSTAMBLE cycles, then go to IDLE.
- Outside DATA, q0 and fall stage 0 load 0.
- q1: fall stage 0 when FALL_DELAY=0; one further register stage when FALL_DELAY=1.
- Latency: a beat accepted at edge N appears on q0 after edge N. The same beat's fall word appears on q1 after edge N+FALL_DELAY.
- oe: registered. It rises on the edge leaving IDLE and stays high through PRE, DATA and POSTAMBLE cycles, plus FALL_DELAY extra cycles. The total high time is PREAMBLE+BURST_LEN+POSTAMBLE+FALL_DELAY cycles.
- dqs_en: registered; high for the BURST_LEN cycles following the first DATA edge.
- busy: high whenever state != IDLE.
- underrun: sticky. err_clr=1 clears it. If an underrun slot and err_clr occur on the same edge, the set wins.
- in_valid is ignored in PRE and POST. The bank never back-pressures mid-burst.

Optional Feature:
- Macro: DDR_OUT_SEAMLESS_EN.
- Defined: in the first POST cycle in_ready=1. If in_valid=1 on that edge, the beat is accepted as beat 0 of a new burst and the FSM returns to DATA with the counter at 1. oe and dqs_en stay continuously high, and no preamble is inserted.
- Not defined: POST always completes, then IDLE is entered. A new burst always pays PREAMBLE+1 cycles.

Test Plan:
- Defaults; hold in_valid=1 and feed beats d0=0x1111..0x4444, d1=0xA1A1..0xA4A4 -> in_ready high 4 cycles; q0 sequence 0x1111..0x4444; q1 the same sequence one cycle later; oe high 7 cycles; dqs_en high 4; underrun=0.
- Drop in_valid on beat 2 only -> q0=0 in that slot; burst still 4 beats; underrun=1 until err_clr pulse; err_clr asserted on the same edge as a new underrun -> underrun stays 1.
- FALL_DELAY=0, PREAMBLE=0 -> q1 aligned with q0; oe high BURST_LEN+POSTAMBLE=5 cycles; DATA entered on the edge after in_valid.
- Pull sys_rst_n low asynchronously mid-DATA -> q0, q1, oe, dqs_en, busy go to 0 without a clock edge; after release, in_ready=0 until a new in_valid is seen in IDLE.
- With DDR_OUT_SEAMLESS_EN, assert in_valid in the first POST cycle -> in_ready=1; two bursts produce 8 contiguous dqs_en cycles; oe never drops.
- Without DDR_OUT_SEAMLESS_EN, same stimulus -> in_ready=0 in POST; oe deasserts, then re-asserts with a 1-cycle preamble.
